// File: rtl/gate_response_checker.sv
// -----------------------------------------------------------------------------
// gate_response_checker
//
// Purpose:
//   Sink side of the gate-exercise stimulus path. Each beat carries the sampled
//   stimulus {a,b} together with the observed AND/OR gate outputs. Every
//   accepted beat is checked against the AND/OR truth table. Matching and
//   mismatching beats are counted with saturating counters. Coverage of the
//   four {a,b} combinations is tracked, and done/pass is reported once every
//   combination has collected REQ_HITS passing beats.
//
// Parameters:
//   CNT_W    - width of the saturating pass/fail counters
//   REQ_HITS - passing beats per {a,b} combination needed to cover it (1..15)
//
// Ports:
//   i_clk              clock, every register updates on the rising edge
//   i_rst              synchronous active-high reset, aborts any run
//   i_start            single-cycle pulse that begins or restarts a run
//   i_in_valid         beat valid
//   o_in_ready         beat can be accepted (RUN and no start this cycle)
//   i_in_a / i_in_b    stimulus inputs
//   i_in_and / i_in_or observed gate outputs
//   o_busy             FSM is in RUN
//   o_done             FSM is in DONE
//   o_pass             done with no failures
//   o_pass_cnt         matching beats this run
//   o_fail_cnt         mismatching beats this run
//   o_cov              bit {a,b} set once that combination has REQ_HITS passes
//   o_first_fail       {a,b,and,or} of the first mismatching beat
//   o_first_fail_vld   o_first_fail holds a captured beat
// -----------------------------------------------------------------------------
module gate_response_checker #(
  parameter int CNT_W    = 8,
  parameter int REQ_HITS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_in_a,
  input  logic             i_in_b,
  input  logic             i_in_and,
  input  logic             i_in_or,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic [CNT_W-1:0] o_fail_cnt,
  output logic [3:0]       o_cov,
  output logic [3:0]       o_first_fail,
  output logic             o_first_fail_vld
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [3:0]       HIT_MAX  = 4'(REQ_HITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // A beat matches only when both observed outputs agree with the truth table.
  function automatic logic beat_matches(input logic a, input logic b,
                                        input logic obs_and, input logic obs_or);
    return (obs_and == (a & b)) && (obs_or == (a | b));
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] res;
    if (v == CNT_MAX) begin
      res = CNT_MAX;
    end else begin
      res = v + CNT_ONE;
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State and result registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [3:0]       r_hit [0:3];
  logic [3:0]       r_cov;
  logic [3:0]       r_first_fail;
  logic             r_first_fail_vld;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_pass_cnt_nxt;
  logic [CNT_W-1:0] w_fail_cnt_nxt;
  logic [3:0]       w_hit_nxt [0:3];
  logic [3:0]       w_cov_nxt;
  logic [3:0]       w_first_fail_nxt;
  logic             w_first_fail_vld_nxt;

  logic             w_ready;
  logic             w_accept;
  logic             w_match;
  logic [1:0]       w_idx;

  // Handshake: a beat offered together with start is dropped on purpose so
  // that the restart always begins from cleared results.
  assign w_ready  = (r_state == ST_RUN) && !i_start;
  assign w_accept = i_in_valid && w_ready;
  assign w_match  = beat_matches(i_in_a, i_in_b, i_in_and, i_in_or);
  assign w_idx    = {i_in_a, i_in_b};

  // Result datapath: clear on start, update counters/coverage on accepted beats.
  always_comb begin
    w_pass_cnt_nxt       = r_pass_cnt;
    w_fail_cnt_nxt       = r_fail_cnt;
    w_first_fail_nxt     = r_first_fail;
    w_first_fail_vld_nxt = r_first_fail_vld;
    for (int i = 0; i < 4; i++) begin
      w_hit_nxt[i] = r_hit[i];
    end

    if (i_start) begin
      w_pass_cnt_nxt       = CNT_ZERO;
      w_fail_cnt_nxt       = CNT_ZERO;
      w_first_fail_nxt     = 4'b0000;
      w_first_fail_vld_nxt = 1'b0;
      for (int i = 0; i < 4; i++) begin
        w_hit_nxt[i] = 4'd0;
      end
    end else if (w_accept) begin
      if (w_match) begin
        w_pass_cnt_nxt = sat_inc(r_pass_cnt);
        // Only the combination carried by this beat earns credit; the hit
        // count stops at REQ_HITS so coverage is a simple equality test.
        for (int i = 0; i < 4; i++) begin
          if ((w_idx == 2'(i)) && (r_hit[i] != HIT_MAX)) begin
            w_hit_nxt[i] = r_hit[i] + 4'd1;
          end else begin
            w_hit_nxt[i] = r_hit[i];
          end
        end
      end else begin
        w_fail_cnt_nxt = sat_inc(r_fail_cnt);
        // Keep the very first mismatch; later ones only bump the counter.
        if (!r_first_fail_vld) begin
          w_first_fail_nxt     = {i_in_a, i_in_b, i_in_and, i_in_or};
          w_first_fail_vld_nxt = 1'b1;
        end else begin
          w_first_fail_nxt     = r_first_fail;
          w_first_fail_vld_nxt = r_first_fail_vld;
        end
      end
    end else begin
      w_pass_cnt_nxt       = r_pass_cnt;
      w_fail_cnt_nxt       = r_fail_cnt;
      w_first_fail_nxt     = r_first_fail;
      w_first_fail_vld_nxt = r_first_fail_vld;
    end

    for (int i = 0; i < 4; i++) begin
      w_cov_nxt[i] = (w_hit_nxt[i] == HIT_MAX);
    end
  end

  // Next-state logic for the IDLE/RUN/DONE controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Looking at next-cycle coverage lets DONE rise on the same edge
        // that records the completing beat.
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else if (w_cov_nxt == 4'b1111) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= ST_IDLE;
      r_pass_cnt       <= CNT_ZERO;
      r_fail_cnt       <= CNT_ZERO;
      r_cov            <= 4'b0000;
      r_first_fail     <= 4'b0000;
      r_first_fail_vld <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_hit[i] <= 4'd0;
      end
    end else begin
      r_state          <= w_state_nxt;
      r_pass_cnt       <= w_pass_cnt_nxt;
      r_fail_cnt       <= w_fail_cnt_nxt;
      r_cov            <= w_cov_nxt;
      r_first_fail     <= w_first_fail_nxt;
      r_first_fail_vld <= w_first_fail_vld_nxt;
      for (int i = 0; i < 4; i++) begin
        r_hit[i] <= w_hit_nxt[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: everything except ready is a register or a decode of registers.
  // ---------------------------------------------------------------------------
  assign o_in_ready       = w_ready;
  assign o_busy           = (r_state == ST_RUN);
  assign o_done           = (r_state == ST_DONE);
  assign o_pass           = (r_state == ST_DONE) && (r_fail_cnt == CNT_ZERO);
  assign o_pass_cnt       = r_pass_cnt;
  assign o_fail_cnt       = r_fail_cnt;
  assign o_cov            = r_cov;
  assign o_first_fail     = r_first_fail;
  assign o_first_fail_vld = r_first_fail_vld;

endmodule

// File: tb/tb_gate_response_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_response_checker
//
// Self-checking bench. The main instance uses default parameters and is
// compared against a behavioural model kept in plain integers. A second
// instance (CNT_W=2, REQ_HITS=2) exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_gate_response_checker;

  localparam int REQ     = 1;
  localparam int CNT_MAX = 255;

  logic clk;
  logic rst;
  logic start, in_valid, in_a, in_b, in_and, in_or;
  logic in_ready, busy, done, pass, ffv;
  logic [7:0] pass_cnt, fail_cnt;
  logic [3:0] cov, first_fail;

  logic s_start, s_valid, s_a, s_b, s_and, s_or;
  logic s_ready, s_busy, s_done, s_pass, s_ffv;
  logic [1:0] s_pass_cnt, s_fail_cnt;
  logic [3:0] s_cov, s_ff;

  int total = 0;
  int bad   = 0;

  // Behavioural model: 0=idle, 1=running, 2=finished
  int         m_st;
  int         m_pass, m_fail;
  int         m_hits [4];
  logic       m_ffv;
  logic [3:0] m_ff;

  gate_response_checker #(.CNT_W(8), .REQ_HITS(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_in_a(in_a), .i_in_b(in_b), .i_in_and(in_and),
    .i_in_or(in_or), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_pass_cnt(pass_cnt), .o_fail_cnt(fail_cnt), .o_cov(cov),
    .o_first_fail(first_fail), .o_first_fail_vld(ffv)
  );

  gate_response_checker #(.CNT_W(2), .REQ_HITS(2)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_in_valid(s_valid),
    .o_in_ready(s_ready), .i_in_a(s_a), .i_in_b(s_b), .i_in_and(s_and),
    .i_in_or(s_or), .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass),
    .o_pass_cnt(s_pass_cnt), .o_fail_cnt(s_fail_cnt), .o_cov(s_cov),
    .o_first_fail(s_ff), .o_first_fail_vld(s_ffv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model_cov();
    logic [3:0] c;
    for (int i = 0; i < 4; i++) c[i] = (m_hits[i] >= REQ);
    return c;
  endfunction

  function automatic logic [27:0] exp_vec();
    return {m_st == 1, m_st == 2, (m_st == 2) && (m_fail == 0),
            8'(m_pass), 8'(m_fail), model_cov(), m_ff, m_ffv};
  endfunction

  function automatic logic [27:0] obs_vec();
    return {busy, done, pass, pass_cnt, fail_cnt, cov, first_fail, ffv};
  endfunction

  task automatic model_clear();
    m_pass = 0; m_fail = 0; m_ffv = 1'b0; m_ff = 4'b0000;
    for (int i = 0; i < 4; i++) m_hits[i] = 0;
  endtask

  // Advance the model by one clock edge given what the DUT sees at that edge.
  task automatic model_edge(input logic r, input logic st, input logic v,
                            input logic [3:0] bt);
    bit a, b, acc, all;
    int idx;
    a = bt[3]; b = bt[2];
    if (r) begin
      m_st = 0; model_clear();
    end else begin
      acc = v && (m_st == 1) && !st;
      if (st) begin
        model_clear(); m_st = 1;
      end else if (acc) begin
        if (bt[1] == (a & b) && bt[0] == (a | b)) begin
          if (m_pass < CNT_MAX) m_pass++;
          idx = (a ? 2 : 0) + (b ? 1 : 0);
          if (m_hits[idx] < REQ) m_hits[idx]++;
        end else begin
          if (m_fail < CNT_MAX) m_fail++;
          if (!m_ffv) begin m_ffv = 1'b1; m_ff = bt; end
        end
        all = 1'b1;
        for (int i = 0; i < 4; i++) if (m_hits[i] < REQ) all = 1'b0;
        if (all) m_st = 2;
      end
    end
  endtask

  task automatic cyc(input logic st, input logic v, input logic [3:0] bt);
    start = st; in_valid = v; {in_a, in_b, in_and, in_or} = bt;
    model_edge(1'b0, st, v, bt);
    @(posedge clk); #1;
  endtask

  task automatic rst_cycles(input int n);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      model_edge(1'b1, 1'b0, 1'b0, 4'b0000);
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst_cycles(2);
    total++;
    if (obs_vec() !== 28'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", obs_vec(), 28'h0);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 4'($urandom_range(0, 15)));
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL idle_ready cyc=%0d got=%b want=0", i, in_ready);
      end
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL idle_state cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_clean_sweep();
    logic [3:0] beats [4];
    beats = '{4'b0000, 4'b0101, 4'b1001, 4'b1111};
    cyc(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, beats[i]);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL sweep_beat%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if ({done, pass, cov, pass_cnt, fail_cnt} !== {1'b1, 1'b1, 4'b1111, 8'd4, 8'd0}) begin
      bad++; $display("FAIL sweep_final got done=%b pass=%b cov=%b pc=%0d fc=%0d want 1 1 1111 4 0",
                      done, pass, cov, pass_cnt, fail_cnt);
    end
    // Results must hold in DONE even with more valid beats offered.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'b1011);
    total++;
    if (obs_vec() !== exp_vec() || in_ready !== 1'b0) begin
      bad++; $display("FAIL done_hold got=%h rdy=%b want=%h rdy=0", obs_vec(), in_ready, exp_vec());
    end
  endtask

  task automatic test_fault_capture();
    logic [3:0] beats [5];
    beats = '{4'b0000, 4'b0101, 4'b1011, 4'b1001, 4'b1111};
    cyc(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, beats[i]);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL fault_beat%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if ({fail_cnt, first_fail, ffv, done, pass} !== {8'd1, 4'b1011, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL fault_final got fc=%0d ff=%b vld=%b done=%b pass=%b want 1 1011 1 1 0",
                      fail_cnt, first_fail, ffv, done, pass);
    end
  endtask

  task automatic test_handshake();
    logic       st, v, rdy_exp;
    logic [3:0] bt;
    logic [1:0] ab;
    cyc(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 60; i++) begin
      st = (i == 20) || (i == 45);
      v  = (i == 20) ? 1'b1 : 1'($urandom_range(0, 1));
      ab = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) bt = {ab, 2'($urandom_range(0, 3))};
      else                           bt = {ab, ab[1] & ab[0], ab[1] | ab[0]};
      start = st; in_valid = v;
      if (v) {in_a, in_b, in_and, in_or} = bt;
      else   {in_a, in_b, in_and, in_or} = 4'bxxxx;
      #1;
      rdy_exp = (m_st == 1) && !st;
      total++;
      if (in_ready !== rdy_exp) begin
        bad++; $display("FAIL hs_ready cyc=%0d got=%b want=%b", i, in_ready, rdy_exp);
      end
      model_edge(1'b0, st, v, bt);
      @(posedge clk); #1;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL hs_state cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      if (i == 20) begin
        total++;
        if ({pass_cnt, fail_cnt, busy} !== {8'd0, 8'd0, 1'b1}) begin
          bad++; $display("FAIL hs_restart got pc=%0d fc=%0d busy=%b want 0 0 1",
                          pass_cnt, fail_cnt, busy);
        end
      end
    end
  endtask

  task automatic test_saturation();
    s_start = 1'b1; s_valid = 1'b0; {s_a, s_b, s_and, s_or} = 4'b0000;
    @(posedge clk); #1;
    s_start = 1'b0; s_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        total++;
        if ({s_pass_cnt, s_cov} !== {2'd1, 4'b0000}) begin
          bad++; $display("FAIL sat_one got pc=%0d cov=%b want 1 0000", s_pass_cnt, s_cov);
        end
      end
      if (i == 2) begin
        total++;
        if ({s_pass_cnt, s_cov} !== {2'd2, 4'b0001}) begin
          bad++; $display("FAIL sat_two got pc=%0d cov=%b want 2 0001", s_pass_cnt, s_cov);
        end
      end
    end
    s_valid = 1'b0;
    total++;
    if ({s_pass_cnt, s_fail_cnt, s_cov, s_busy, s_done} !== {2'd3, 2'd0, 4'b0001, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sat_final got pc=%0d fc=%0d cov=%b busy=%b done=%b want 3 0 0001 1 0",
                      s_pass_cnt, s_fail_cnt, s_cov, s_busy, s_done);
    end
  endtask

  task automatic test_reset_midrun();
    cyc(1'b1, 1'b0, 4'b0000);
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b0, 1'b1, 4'b0101);
    in_valid = 1'b1;
    rst = 1'b1;
    model_edge(1'b1, 1'b0, 1'b1, 4'b1001);
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (obs_vec() !== 28'h0) begin
      bad++; $display("FAIL midrun_rst got=%h want=%h", obs_vec(), 28'h0);
    end
    cyc(1'b1, 1'b0, 4'b0000);
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b0, 1'b1, 4'b0101);
    total++;
    if ({busy, done, cov} !== {1'b1, 1'b0, 4'b0011}) begin
      bad++; $display("FAIL midrun_partial got busy=%b done=%b cov=%b want 1 0 0011", busy, done, cov);
    end
    cyc(1'b0, 1'b1, 4'b1001);
    cyc(1'b0, 1'b1, 4'b1111);
    total++;
    if (obs_vec() !== exp_vec() || done !== 1'b1) begin
      bad++; $display("FAIL midrun_complete got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    {in_a, in_b, in_and, in_or} = 4'b0000;
    s_start = 1'b0; s_valid = 1'b0; {s_a, s_b, s_and, s_or} = 4'b0000;
    m_st = 0; model_clear();
    @(posedge clk); #1;
    test_reset();
    test_clean_sweep();
    test_fault_capture();
    test_handshake();
    test_saturation();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
